// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue sequencer: RoB tag width, RV32I opcode
// constants, FSM state encoding and the opcode classification helpers.
package issue_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = 3;

  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] R_TYPE  = 7'b0110011;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } issue_state_e;

  typedef enum logic {
    UNIT_RS  = 1'b0,
    UNIT_LSB = 1'b1
  } unit_e;

  // Memory ops go to the load/store buffer, everything else to the RS.
  function automatic unit_e unit_of(input logic [6:0] op);
    unit_e u;
    case (op)
      LD_TYPE, S_TYPE:                                     u = UNIT_LSB;
      R_TYPE, I_TYPE, B_TYPE, LUI, AUIPC, JAL, JALR:       u = UNIT_RS;
      default:                                             u = UNIT_RS;
    endcase
    return u;
  endfunction

  // Stores and branches never write a register; neither does rd = x0.
  function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
    return (op != S_TYPE) && (op != B_TYPE) && (rd != 5'd0);
  endfunction

  // LUI, AUIPC and JAL have no rs1 operand.
  function automatic logic keeps_rs1(input logic [6:0] op);
    return (op != LUI) && (op != AUIPC) && (op != JAL);
  endfunction

  // Only R-type, stores and branches read rs2.
  function automatic logic keeps_rs2(input logic [6:0] op);
    return (op == R_TYPE) || (op == S_TYPE) || (op == B_TYPE);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Bundle of decoder, CDB, back-end and rename signals around issue_ctrl.
// The slave modport is the sequencer's view; master is the environment's.
interface issue_ctrl_if
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_SIZE_WIDTH
);
  // Global control
  logic             rdy;
  logic             clear;
  // Decoder side
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_imm;
  logic [31:0]      dec_val1;
  logic [31:0]      dec_val2;
  logic             dec_dep1;
  logic             dec_dep2;
  logic [ROB_W-1:0] dec_q1;
  logic [ROB_W-1:0] dec_q2;
  // Common data buses
  logic             cdb_alu_valid;
  logic [ROB_W-1:0] cdb_alu_id;
  logic [31:0]      cdb_alu_val;
  logic             cdb_lsb_valid;
  logic [ROB_W-1:0] cdb_lsb_id;
  logic [31:0]      cdb_lsb_val;
  // Back-end status
  logic             rob_full;
  logic [ROB_W-1:0] rob_tail;
  logic             rs_full;
  logic             lsb_full;
  // Issue strobes and payload
  logic             rob_issue;
  logic             rs_issue;
  logic             lsb_issue;
  logic [31:0]      iss_instr;
  logic [31:0]      iss_pc;
  logic [31:0]      iss_imm;
  logic [31:0]      iss_val1;
  logic [31:0]      iss_val2;
  logic             iss_dep1;
  logic             iss_dep2;
  logic [ROB_W-1:0] iss_q1;
  logic [ROB_W-1:0] iss_q2;
  logic [ROB_W-1:0] iss_rob_id;
  // Rename port
  logic             ren_en;
  logic [4:0]       ren_rd;
  logic [ROB_W-1:0] ren_id;

  modport slave (
    input  rdy, clear,
    input  dec_valid, dec_instr, dec_pc, dec_imm,
    input  dec_val1, dec_val2, dec_dep1, dec_dep2, dec_q1, dec_q2,
    input  cdb_alu_valid, cdb_alu_id, cdb_alu_val,
    input  cdb_lsb_valid, cdb_lsb_id, cdb_lsb_val,
    input  rob_full, rob_tail, rs_full, lsb_full,
    output dec_ready,
    output rob_issue, rs_issue, lsb_issue,
    output iss_instr, iss_pc, iss_imm, iss_val1, iss_val2,
    output iss_dep1, iss_dep2, iss_q1, iss_q2, iss_rob_id,
    output ren_en, ren_rd, ren_id
  );

  modport master (
    output rdy, clear,
    output dec_valid, dec_instr, dec_pc, dec_imm,
    output dec_val1, dec_val2, dec_dep1, dec_dep2, dec_q1, dec_q2,
    output cdb_alu_valid, cdb_alu_id, cdb_alu_val,
    output cdb_lsb_valid, cdb_lsb_id, cdb_lsb_val,
    output rob_full, rob_tail, rs_full, lsb_full,
    input  dec_ready,
    input  rob_issue, rs_issue, lsb_issue,
    input  iss_instr, iss_pc, iss_imm, iss_val1, iss_val2,
    input  iss_dep1, iss_dep2, iss_q1, iss_q2, iss_rob_id,
    input  ren_en, ren_rd, ren_id
  );

endinterface

// File: rtl/issue_ctrl_cdb_bypass.sv
// cdb_bypass: resolves one waiting operand against both result buses.
// If the operand is still pending and a bus broadcasts its tag, the operand
// becomes ready with the broadcast value. The ALU bus wins a (illegal) tie.
module issue_ctrl_cdb_bypass
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_SIZE_WIDTH
) (
  input  logic             dep_in,
  input  logic [ROB_W-1:0] tag,
  input  logic [31:0]      val_in,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_id,
  input  logic [31:0]      alu_val,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_id,
  input  logic [31:0]      lsb_val,
  output logic             dep_out,
  output logic [31:0]      val_out
);

  // Tag match against ALU bus first, then LSB bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dep_out = dep_in;
    val_out = val_in;
    if (dep_in && alu_valid && (alu_id == tag)) begin
      dep_out = 1'b0;
      val_out = alu_val;
    end else if (dep_in && lsb_valid && (lsb_id == tag)) begin
      dep_out = 1'b0;
      val_out = lsb_val;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: one-entry dispatch sequencer between decoder and back-end.
// Holds a decoded instruction until the RoB and its target unit (RS or LSB)
// can both take it, snoops the CDBs meanwhile, then issues and renames rd.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_W = ROB_SIZE_WIDTH
) (
  input logic        clk,
  input logic        rst,
  issue_ctrl_if.slave bus
);

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      val1;
    logic [31:0]      val2;
    logic             dep1;
    logic             dep2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
  } hold_t;

  issue_state_e state_q, state_d;
  hold_t        hold_q, hold_d;

  logic        hold_valid;
  logic        to_lsb;
  logic        need;
  logic        fire;
  logic        dec_ready_c;
  logic        accept;

  logic        in_dep1, in_dep2;
  logic        cap_dep1, cap_dep2;
  logic [31:0] cap_val1, cap_val2;
  logic        byp_dep1, byp_dep2;
  logic [31:0] byp_val1, byp_val2;

  assign hold_valid = (state_q == ST_HOLD);
  assign to_lsb     = (unit_of(hold_q.instr[6:0]) == UNIT_LSB);

  // Operands the opcode does not read must never wait on a tag.
  assign in_dep1 = bus.dec_dep1 & keeps_rs1(bus.dec_instr[6:0]);
  assign in_dep2 = bus.dec_dep2 & keeps_rs2(bus.dec_instr[6:0]);

  // Capture path: resolve incoming operands against this cycle's broadcasts.
  issue_ctrl_cdb_bypass #(.ROB_W(ROB_W)) u_cap1 (
    .dep_in (in_dep1),           .tag    (bus.dec_q1),        .val_in (bus.dec_val1),
    .alu_valid(bus.cdb_alu_valid), .alu_id(bus.cdb_alu_id),   .alu_val(bus.cdb_alu_val),
    .lsb_valid(bus.cdb_lsb_valid), .lsb_id(bus.cdb_lsb_id),   .lsb_val(bus.cdb_lsb_val),
    .dep_out(cap_dep1),          .val_out(cap_val1)
  );

  issue_ctrl_cdb_bypass #(.ROB_W(ROB_W)) u_cap2 (
    .dep_in (in_dep2),           .tag    (bus.dec_q2),        .val_in (bus.dec_val2),
    .alu_valid(bus.cdb_alu_valid), .alu_id(bus.cdb_alu_id),   .alu_val(bus.cdb_alu_val),
    .lsb_valid(bus.cdb_lsb_valid), .lsb_id(bus.cdb_lsb_id),   .lsb_val(bus.cdb_lsb_val),
    .dep_out(cap_dep2),          .val_out(cap_val2)
  );

  // Issue path: held operands with a same-cycle broadcast folded in. The same
  // result also refreshes the hold register when the entry keeps waiting.
  issue_ctrl_cdb_bypass #(.ROB_W(ROB_W)) u_byp1 (
    .dep_in (hold_q.dep1),       .tag    (hold_q.q1),         .val_in (hold_q.val1),
    .alu_valid(bus.cdb_alu_valid), .alu_id(bus.cdb_alu_id),   .alu_val(bus.cdb_alu_val),
    .lsb_valid(bus.cdb_lsb_valid), .lsb_id(bus.cdb_lsb_id),   .lsb_val(bus.cdb_lsb_val),
    .dep_out(byp_dep1),          .val_out(byp_val1)
  );

  issue_ctrl_cdb_bypass #(.ROB_W(ROB_W)) u_byp2 (
    .dep_in (hold_q.dep2),       .tag    (hold_q.q2),         .val_in (hold_q.val2),
    .alu_valid(bus.cdb_alu_valid), .alu_id(bus.cdb_alu_id),   .alu_val(bus.cdb_alu_val),
    .lsb_valid(bus.cdb_lsb_valid), .lsb_id(bus.cdb_lsb_id),   .lsb_val(bus.cdb_lsb_val),
    .dep_out(byp_dep2),          .val_out(byp_val2)
  );

  // FSM next state plus the issue/accept handshake decisions.
  always_comb begin
    state_d     = state_q;
    need        = bus.rob_full | (to_lsb ? bus.lsb_full : bus.rs_full);
    fire        = bus.rdy & ~bus.clear & hold_valid & ~need;
    dec_ready_c = bus.rdy & ~bus.clear & (~hold_valid | fire);
    accept      = bus.dec_valid & dec_ready_c;
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.rdy && bus.clear) state_d = ST_EMPTY;
        else if (accept)          state_d = ST_HOLD;
        else if (fire)            state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register; rdy low freezes it because state_d equals state_q then.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next hold contents: new instruction on accept, else snoop the CDBs.
  always_comb begin
    hold_d = hold_q;
    if (accept) begin
      hold_d.instr = bus.dec_instr;
      hold_d.pc    = bus.dec_pc;
      hold_d.imm   = bus.dec_imm;
      hold_d.val1  = cap_val1;
      hold_d.val2  = cap_val2;
      hold_d.dep1  = cap_dep1;
      hold_d.dep2  = cap_dep2;
      hold_d.q1    = bus.dec_q1;
      hold_d.q2    = bus.dec_q2;
    end else begin
      hold_d.val1  = byp_val1;
      hold_d.val2  = byp_val2;
      hold_d.dep1  = byp_dep1;
      hold_d.dep2  = byp_dep2;
    end
  end

  // Hold register; only updated while the pipeline is enabled.
  always_ff @(posedge clk) begin
    // NOTE: the hold register is ordinary flops, not a memory, so it is cleared at reset and the payload is deterministic.
    if (rst)          hold_q <= '0;
    else if (bus.rdy) hold_q <= hold_d;
  end

  assign bus.dec_ready  = dec_ready_c;
  assign bus.rob_issue  = fire;
  assign bus.rs_issue   = fire & ~to_lsb;
  assign bus.lsb_issue  = fire & to_lsb;

  assign bus.iss_instr  = hold_q.instr;
  assign bus.iss_pc     = hold_q.pc;
  assign bus.iss_imm    = hold_q.imm;
  assign bus.iss_val1   = byp_val1;
  assign bus.iss_val2   = byp_val2;
  assign bus.iss_dep1   = byp_dep1;
  assign bus.iss_dep2   = byp_dep2;
  assign bus.iss_q1     = hold_q.q1;
  assign bus.iss_q2     = hold_q.q2;
  assign bus.iss_rob_id = bus.rob_tail;

  assign bus.ren_en     = fire & writes_rd(hold_q.instr[6:0], hold_q.instr[11:7]);
  assign bus.ren_rd     = hold_q.instr[11:7];
  assign bus.ren_id     = bus.rob_tail;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: a directed per-cycle vector table, a reset-in-HOLD
// sequence, then randomized traffic compared against a behavioural model.
module tb_issue_ctrl;

  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_ctrl_if #(.ROB_W(RW)) bus ();

  issue_ctrl #(.ROB_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction encodings used by the directed table.
  localparam logic [31:0] ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] ADD7  = 32'h002083B3; // add  x7,x1,x2
  localparam logic [31:0] LW4   = 32'h0000A203; // lw   x4,0(x1)
  localparam logic [31:0] SW5   = 32'h00532023; // sw   x5,0(x6)
  localparam logic [31:0] BEQ   = 32'h00208063; // beq  x1,x2,0
  localparam logic [31:0] ADDI0 = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00100113;
  localparam logic [31:0] ADDI3 = 32'h00100193;
  localparam logic [31:0] ADDI4 = 32'h00100213;
  localparam logic [31:0] ADDI5 = 32'h00100293;
  localparam logic [31:0] LUI1  = 32'h000010B7; // lui  x1,1

  typedef struct packed {
    logic          frz;     // drives rdy low
    logic          clr;
    logic          dv;
    logic [31:0]   instr;
    logic          d1;
    logic [RW-1:0] q1;
    logic [31:0]   v1;
    logic          robf;
    logic          rsf;
    logic          lsbf;
    logic [RW-1:0] tail;
    logic          av;
    logic [RW-1:0] aid;
    logic [31:0]   aval;
    logic          e_rdy;
    logic          e_rob;
    logic          e_rs;
    logic          e_lsb;
    logic          e_ren;
    logic [4:0]    e_rd;
    logic          chk_op;
    logic          e_dep1;
    logic [31:0]   e_val1;
  } vec_t;

  localparam int NROWS = 32;
  vec_t tbl [NROWS];

  task automatic drive_idle();
    bus.rdy = 1'b1;           bus.clear = 1'b0;
    bus.dec_valid = 1'b0;     bus.dec_instr = '0;  bus.dec_pc = '0;  bus.dec_imm = '0;
    bus.dec_val1 = '0;        bus.dec_val2 = '0;
    bus.dec_dep1 = 1'b0;      bus.dec_dep2 = 1'b0; bus.dec_q1 = '0;  bus.dec_q2 = '0;
    bus.cdb_alu_valid = 1'b0; bus.cdb_alu_id = '0; bus.cdb_alu_val = '0;
    bus.cdb_lsb_valid = 1'b0; bus.cdb_lsb_id = '0; bus.cdb_lsb_val = '0;
    bus.rob_full = 1'b0;      bus.rob_tail = '0;   bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
  endtask

  task automatic apply_row(input vec_t v);
    drive_idle();
    bus.rdy = ~v.frz;      bus.clear = v.clr;
    bus.dec_valid = v.dv;  bus.dec_instr = v.instr;
    bus.dec_pc = 32'h0000_1000; bus.dec_imm = 32'h4;
    bus.dec_dep1 = v.d1;   bus.dec_q1 = v.q1;  bus.dec_val1 = v.v1;
    bus.rob_full = v.robf; bus.rs_full = v.rsf; bus.lsb_full = v.lsbf;
    bus.rob_tail = v.tail;
    bus.cdb_alu_valid = v.av; bus.cdb_alu_id = v.aid; bus.cdb_alu_val = v.aval;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit            valid;
    logic [31:0]   instr, pc, imm, v1, v2;
    bit            d1, d2;
    logic [RW-1:0] q1, q2;
  } slot_t;

  slot_t m;

  function automatic bit m_is_mem(input logic [31:0] ins);
    return ins[6:0] == 7'h03 || ins[6:0] == 7'h23;
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    return ins[6:0] != 7'h23 && ins[6:0] != 7'h63 && ins[11:7] != 5'd0;
  endfunction

  function automatic bit m_reads1(input logic [31:0] ins);
    return !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
  endfunction

  function automatic bit m_reads2(input logic [31:0] ins);
    return ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
  endfunction

  // A pending operand picks up whichever bus broadcasts its tag (ALU first).
  task automatic m_resolve(input bit d, input logic [RW-1:0] q, input logic [31:0] v,
                           output bit d_o, output logic [31:0] v_o);
    d_o = d; v_o = v;
    if (d && bus.cdb_alu_valid && bus.cdb_alu_id == q) begin
      d_o = 0; v_o = bus.cdb_alu_val;
    end else if (d && bus.cdb_lsb_valid && bus.cdb_lsb_id == q) begin
      d_o = 0; v_o = bus.cdb_lsb_val;
    end
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    string nm;
    rst = 1'b1;
    drive_idle();

    // ---------------- directed table ----------------
    tbl[0]  = '{e_rdy:1, default:0};
    tbl[1]  = '{dv:1, instr:ADD3, v1:32'h11, tail:5, e_rdy:1, default:0};
    tbl[2]  = '{tail:5, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:3, chk_op:1, e_val1:32'h11, default:0};
    tbl[3]  = '{dv:1, instr:LW4, lsbf:1, e_rdy:1, default:0};
    tbl[4]  = '{dv:1, instr:SW5, lsbf:1, default:0};
    tbl[5]  = '{dv:1, instr:SW5, lsbf:1, default:0};
    tbl[6]  = '{dv:1, instr:SW5, lsbf:1, default:0};
    tbl[7]  = '{dv:1, instr:SW5, tail:1, e_rdy:1, e_rob:1, e_lsb:1, e_ren:1, e_rd:4, default:0};
    tbl[8]  = '{dv:1, instr:BEQ, tail:2, e_rdy:1, e_rob:1, e_lsb:1, default:0};
    tbl[9]  = '{dv:1, instr:ADDI0, tail:3, e_rdy:1, e_rob:1, e_rs:1, default:0};
    tbl[10] = '{dv:1, instr:ADD7, d1:1, q1:2, tail:4, e_rdy:1, e_rob:1, e_rs:1, default:0};
    tbl[11] = '{rsf:1, av:1, aid:2, aval:32'hDEADBEEF, default:0};
    tbl[12] = '{rsf:1, default:0};
    tbl[13] = '{dv:1, instr:ADD7, d1:1, q1:2, tail:4, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:7,
                chk_op:1, e_val1:32'hDEADBEEF, default:0};
    tbl[14] = '{rsf:1, default:0};
    tbl[15] = '{dv:1, instr:ADD3, v1:32'h33, tail:5, av:1, aid:2, aval:32'hCAFEF00D, e_rdy:1,
                e_rob:1, e_rs:1, e_ren:1, e_rd:7, chk_op:1, e_val1:32'hCAFEF00D, default:0};
    tbl[16] = '{clr:1, dv:1, instr:ADDI1, default:0};
    tbl[17] = '{e_rdy:1, default:0};
    tbl[18] = '{dv:1, instr:ADDI1, e_rdy:1, default:0};
    tbl[19] = '{dv:1, instr:ADDI2, tail:0, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:1, default:0};
    tbl[20] = '{dv:1, instr:ADDI3, tail:1, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:2, default:0};
    tbl[21] = '{dv:1, instr:ADDI4, tail:2, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:3, default:0};
    tbl[22] = '{tail:3, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:4, default:0};
    tbl[23] = '{frz:1, dv:1, instr:ADDI1, default:0};
    tbl[24] = '{dv:1, instr:ADDI5, e_rdy:1, default:0};
    tbl[25] = '{frz:1, default:0};
    tbl[26] = '{tail:6, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:5, default:0};
    tbl[27] = '{dv:1, instr:ADD3, v1:32'h44, e_rdy:1, default:0};
    tbl[28] = '{robf:1, default:0};
    tbl[29] = '{dv:1, instr:LUI1, d1:1, q1:4, v1:32'h55, tail:7, e_rdy:1, e_rob:1, e_rs:1,
                e_ren:1, e_rd:3, chk_op:1, e_val1:32'h44, default:0};
    tbl[30] = '{tail:0, av:1, aid:4, aval:32'h99, e_rdy:1, e_rob:1, e_rs:1, e_ren:1, e_rd:1,
                chk_op:1, e_val1:32'h55, default:0};
    tbl[31] = '{e_rdy:1, default:0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      apply_row(tbl[i]);
      #2;
      nm = $sformatf("row%0d", i);
      check({nm, " dec_ready"}, bus.dec_ready, tbl[i].e_rdy);
      check({nm, " rob_issue"}, bus.rob_issue, tbl[i].e_rob);
      check({nm, " rs_issue"},  bus.rs_issue,  tbl[i].e_rs);
      check({nm, " lsb_issue"}, bus.lsb_issue, tbl[i].e_lsb);
      check({nm, " ren_en"},    bus.ren_en,    tbl[i].e_ren);
      if (tbl[i].e_ren) begin
        check({nm, " ren_rd"}, bus.ren_rd, tbl[i].e_rd);
        check({nm, " ren_id"}, bus.ren_id, tbl[i].tail);
      end
      if (tbl[i].chk_op) begin
        check({nm, " iss_dep1"}, bus.iss_dep1, tbl[i].e_dep1);
        check({nm, " iss_val1"}, bus.iss_val1, tbl[i].e_val1);
      end
      @(posedge clk); #1;
    end

    // ---------------- reset while holding ----------------
    drive_idle();
    bus.dec_valid = 1'b1; bus.dec_instr = ADD3; bus.dec_val1 = 32'h77;
    @(posedge clk); #1;
    drive_idle();
    bus.rs_full = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rs_full = 1'b0;
    #1;
    check("rst_hold rob_issue", bus.rob_issue, 1'b0);
    check("rst_hold dec_ready", bus.dec_ready, 1'b1);
    check("rst_hold iss_instr", bus.iss_instr, 32'h0);
    check("rst_hold iss_val1",  bus.iss_val1,  32'h0);
    @(posedge clk); #1;

    // ---------------- randomized traffic vs model ----------------
    m.valid = 0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] r;
      bit e_fire, e_ready, e_need, rd1, rd2;
      logic [31:0] rv1, rv2;
      drive_idle();
      bus.rdy       = ($urandom_range(0, 9) != 0);
      bus.clear     = ($urandom_range(0, 19) == 0);
      bus.dec_valid = ($urandom_range(0, 9) < 7);
      r = $urandom;
      bus.dec_instr = {r[31:7], ops[$urandom_range(0, 8)]};
      bus.dec_pc    = $urandom;
      bus.dec_imm   = $urandom;
      bus.dec_val1  = $urandom;
      bus.dec_val2  = $urandom;
      bus.dec_dep1  = $urandom_range(0, 1) == 1;
      bus.dec_dep2  = $urandom_range(0, 1) == 1;
      bus.dec_q1    = RW'($urandom);
      bus.dec_q2    = RW'($urandom);
      bus.rob_full  = ($urandom_range(0, 3) == 0);
      bus.rs_full   = ($urandom_range(0, 3) == 0);
      bus.lsb_full  = ($urandom_range(0, 3) == 0);
      bus.rob_tail  = RW'($urandom);
      bus.cdb_alu_valid = ($urandom_range(0, 9) < 3);
      bus.cdb_alu_id    = RW'($urandom);
      bus.cdb_alu_val   = $urandom;
      bus.cdb_lsb_valid = ($urandom_range(0, 9) < 3);
      bus.cdb_lsb_id    = bus.cdb_alu_id ^ RW'($urandom_range(1, (1 << RW) - 1));
      bus.cdb_lsb_val   = $urandom;
      if (bus.cdb_alu_valid && bus.cdb_lsb_valid && bus.cdb_alu_id == bus.cdb_lsb_id) begin
        n_fail++;
        $display("FAIL cdb_collision: both buses drive tag %0d", bus.cdb_alu_id);
      end
      #2;

      e_need  = bus.rob_full || (m_is_mem(m.instr) ? bus.lsb_full : bus.rs_full);
      e_fire  = bus.rdy && !bus.clear && m.valid && !e_need;
      e_ready = bus.rdy && !bus.clear && (!m.valid || e_fire);
      m_resolve(m.d1, m.q1, m.v1, rd1, rv1);
      m_resolve(m.d2, m.q2, m.v2, rd2, rv2);

      nm = $sformatf("rnd%0d", c);
      check({nm, " dec_ready"}, bus.dec_ready, e_ready);
      check({nm, " rob_issue"}, bus.rob_issue, e_fire);
      check({nm, " rs_issue"},  bus.rs_issue,  e_fire && !m_is_mem(m.instr));
      check({nm, " lsb_issue"}, bus.lsb_issue, e_fire && m_is_mem(m.instr));
      check({nm, " ren_en"},    bus.ren_en,    e_fire && m_writes(m.instr));
      if (e_fire) begin
        check({nm, " iss_instr"},  bus.iss_instr,  m.instr);
        check({nm, " iss_pc"},     bus.iss_pc,     m.pc);
        check({nm, " iss_imm"},    bus.iss_imm,    m.imm);
        check({nm, " iss_dep1"},   bus.iss_dep1,   rd1);
        check({nm, " iss_val1"},   bus.iss_val1,   rv1);
        check({nm, " iss_dep2"},   bus.iss_dep2,   rd2);
        check({nm, " iss_val2"},   bus.iss_val2,   rv2);
        check({nm, " iss_rob_id"}, bus.iss_rob_id, bus.rob_tail);
        if (rd1) check({nm, " iss_q1"}, bus.iss_q1, m.q1);
        if (rd2) check({nm, " iss_q2"}, bus.iss_q2, m.q2);
        if (m_writes(m.instr)) begin
          check({nm, " ren_rd"}, bus.ren_rd, m.instr[11:7]);
          check({nm, " ren_id"}, bus.ren_id, bus.rob_tail);
        end
      end

      // Model state advance for this edge.
      if (bus.rdy) begin
        if (bus.clear) begin
          m.valid = 0;
        end else if (bus.dec_valid && e_ready) begin
          m.valid = 1;
          m.instr = bus.dec_instr; m.pc = bus.dec_pc; m.imm = bus.dec_imm;
          m.q1 = bus.dec_q1; m.q2 = bus.dec_q2;
          m_resolve(bus.dec_dep1 && m_reads1(bus.dec_instr), bus.dec_q1, bus.dec_val1, m.d1, m.v1);
          m_resolve(bus.dec_dep2 && m_reads2(bus.dec_instr), bus.dec_q2, bus.dec_val2, m.d2, m.v2);
        end else if (e_fire) begin
          m.valid = 0;
        end else begin
          m.d1 = rd1; m.v1 = rv1;
          m.d2 = rd2; m.v2 = rv2;
        end
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Dispatch sequencer between the Decoder and the out-of-order back-end: RoB, Reservation Station (RS), Load/Store Buffer (LSB) and register-file rename port.
- Holds one decoded instruction and waits for a free RoB entry plus a free slot in the target unit.
- Captures CDB broadcasts while the instruction waits, so operand dependencies are never lost.
- Issues with one handshake, renames rd and back-pressures the Fetcher/Decoder.

Parameters:
ROB_W, 3, RoB tag width; equals shared ROB_SIZE_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
clear  in  1  mispredict flush from RoB
dec_valid  in  1  decoded instruction present
dec_ready  out  1  issue_ctrl accepts this cycle
dec_instr  in  32  raw instruction
dec_pc  in  32  instruction address
dec_imm  in  32  immediate
dec_val1, dec_val2  in  32  operand values from register file
dec_dep1, dec_dep2  in  1  operand waiting on RoB tag
dec_q1, dec_q2  in  ROB_W  producing RoB tags
cdb_alu_valid  in  1  ALU result broadcast
cdb_alu_id  in  ROB_W  ALU result tag
cdb_alu_val  in  32  ALU result value
cdb_lsb_valid  in  1  LSB result broadcast
cdb_lsb_id  in  ROB_W  LSB result tag
cdb_lsb_val  in  32  LSB result value
rob_full  in  1  RoB cannot allocate
rob_tail  in  ROB_W  tag to be allocated
rs_full  in  1  RS has no free entry
lsb_full  in  1  LSB has no free entry
rob_issue  out  1  allocate RoB entry
rs_issue  out  1  write RS entry
lsb_issue  out  1  write LSB entry
iss_instr, iss_pc, iss_imm  out  32  payload
iss_val1, iss_val2  out  32  operands after bypass
iss_dep1, iss_dep2  out  1  dependency flags after bypass
iss_q1, iss_q2  out  ROB_W  dependency tags
iss_rob_id  out  ROB_W  equals rob_tail
ren_en  out  1  rename rd in register file
ren_rd  out  5  destination register
ren_id  out  ROB_W  new producer tag

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high. Reset clears hold_valid, and all registered fields go to 0.
- State machine: EMPTY (hold_valid=0) and HOLD (hold_valid=1).
- Classification uses opcode bits [6:0]:
  - Load 0000011 and store 0100011 go to LSB.
  - All other opcodes go to RS.
  - has_rd=0 for store and branch 1100011. It is also 0 when rd field [11:7]=0.
- Operand masking at capture:
  - dep1 is forced 0 for LUI, AUIPC and JAL.
  - dep2 is forced 0 for everything except R-type 0110011, store and branch.
- need = rob_full | (to_lsb ? lsb_full : rs_full).
- fire = rdy & ~clear & hold_valid & ~need (combinational).
- dec_ready = rdy & ~clear & (~hold_valid | fire). Back-to-back issue reaches 1 instr/cycle.
- Issue outputs are combinational from the hold register, qualified by fire:
  - rob_issue = fire.
  - rs_issue = fire & ~to_lsb.
  - lsb_issue = fire & to_lsb.
  - Payload is don't-care when fire=0.
- Rename: ren_en = fire & has_rd. ren_rd = rd field; ren_id = rob_tail.
- Latency: an instruction accepted at edge N can issue in cycle N+1 at the earliest.
- CDB capture, every cycle with rdy=1:
  - For each held operand with dep=1 and a matching cdb_*_id, set dep←0 and value←cdb value.
  - The same match is applied to incoming dec_* fields on accept.
- Same-cycle bypass: iss_val/iss_dep reflect a CDB hit in the fire cycle itself.
- Both CDBs hit the same tag: the ALU bus has priority. This cannot legally occur; the bench flags it.
- Accept and fire in the same edge: the hold register is overwritten with the new instruction and hold_valid stays 1.
- clear: hold_valid←0 at the edge. No issue, rename or accept in that cycle. clear dominates dec_valid.
- rdy=0: all outputs 0 except payload, and no state change. CDB capture is also suppressed; the back-end freezes too.
- rst is asserted while in HOLD: the held instruction is discarded and no issue occurs.

Decomposition:
- Shared package/defines hold:
  - ROB_SIZE_WIDTH.
  - Opcode constants LUI, AUIPC, JAL, JALR, B_TYPE, LD_TYPE, S_TYPE, I_TYPE, R_TYPE.
- One natural sub-module: cdb_bypass.
  - Inputs: dep, tag, value, and both CDB buses.
  - Outputs: updated dep and value.
  - Instantiated four times: two for capture and two for the issue-path bypass.

Test Plan:
- ADD x3,x1,x2 with dep=0, RS free, rob_tail=5 → next cycle rs_issue=rob_issue=1, ren_en=1, ren_rd=3, ren_id=5, dec_ready=1.
- LW with lsb_full=1 for 3 cycles → lsb_issue stays 0 and dec_ready=0 for those 3 cycles. Issue occurs in the cycle lsb_full drops.
- Held ADD with dep1=1, q1=2, stalled; cdb_alu_valid=1, id=2, val=0xDEADBEEF → when it issues, iss_dep1=0 and iss_val1=0xDEADBEEF. Repeat with the broadcast landing in the fire cycle itself.
- SW x5,0(x6) → lsb_issue=1 and ren_en=0. BEQ → rs_issue=1 and ren_en=0. ADDI x0 → ren_en=0.
- clear while HOLD with dec_valid=1 → no issue and dec_ready=0 that cycle; EMPTY the next cycle.
- Stream of 4 independent ADDIs with no stalls → 4 consecutive cycles of rs_issue=1. rob_tail increments externally 0,1,2,3 and ren_id matches it.
